lsu: RTL and testbench
======================

# lsu

Load/store pipeline stage between the execute stage and the write-back stage. Registers one instruction per valid/ready handshake, issues at most one data-memory access per instruction, aligns and sign/zero-extends load data, and builds store byte masks. It then presents the result to write-back (`wbu`) with a valid/ready handshake. Non-memory instructions pass through in one cycle.

## Interface
- No parameters. Widths use `` `CPU_WIDTH `` (64) and `` `REG_ADDRW `` (5).
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_pre_valid` in 1: execute stage has an instruction.
- `o_pre_ready` out 1: LSU can accept an instruction.
- `i_exu_exres` in `` `CPU_WIDTH ``: ALU result; this is the effective address for loads and stores.
- `i_exu_rs2` in `` `CPU_WIDTH ``: store data.
- `i_exu_lsfunc` in 3: funct3 size/sign code.
- `i_exu_lden` in 1: load.
- `i_exu_sten` in 1: store.
- `i_exu_rdid` in `` `REG_ADDRW ``: destination register.
- `i_exu_rdwen` in 1: destination write enable.
- `s_exu_diffpc` in `` `CPU_WIDTH ``: simulation PC.
- `o_mem_req` out 1: memory request.
- `o_mem_wen` out 1: request is a store.
- `o_mem_addr` out `` `CPU_WIDTH ``: doubleword-aligned address.
- `o_mem_wdata` out `` `CPU_WIDTH ``: store data, lane-shifted.
- `o_mem_wmask` out 8: store byte mask.
- `i_mem_ack` in 1: request completed; `i_mem_rdata` is valid in the same cycle.
- `i_mem_rdata` in `` `CPU_WIDTH ``: aligned doubleword read data.
- `o_post_valid` out 1: result valid to write-back.
- `i_post_ready` in 1: write-back accepts the result.
- `o_lsu_exres`, `o_lsu_lsres` out `` `CPU_WIDTH ``: ALU result and extended load result.
- `o_lsu_rdid` out `` `REG_ADDRW ``.
- `o_lsu_rdwen`, `o_lsu_lden` out 1.
- `o_lsu_misalign` out 1: misaligned access flag.
- `s_lsu_diffpc` out `` `CPU_WIDTH ``.

## Operation
- States:
  - EMPTY: no instruction held.
  - MEM: request outstanding.
  - HOLD: result held.
- Control signals:
  - `o_pre_ready` = (state==EMPTY) | (state==HOLD & `i_post_ready`).
  - pipewen = `i_pre_valid` & `o_pre_ready`.
- On pipewen, all `i_exu_*` and `s_exu_diffpc` are registered.
  - Next state is MEM if lden|sten, otherwise HOLD.
  - With no pipewen: HOLD & `i_post_ready` → EMPTY.
- MEM:
  - `o_mem_req`=1; addr, wen, wdata and wmask are held stable.
  - `i_mem_ack` → HOLD. For loads, the extended read data is latched into `o_lsu_lsres` in that cycle.
  - `o_pre_ready`=0 in MEM.
- `o_post_valid` = (state==HOLD). All `o_lsu_*` outputs come from registers.
- Addressing: off = exres[2:0]; `o_mem_addr` = {exres[63:3],3'b000}.
- Loads:
  - Data is `i_mem_rdata` >> (off*8).
  - lsfunc 000 lb, 001 lh, 010 lw, 011 ld: sign-extend from 8/16/32/64 bits.
  - lsfunc 100 lbu, 101 lhu, 110 lwu: zero-extend.
  - lsfunc 111: treated as ld.
- Stores:
  - lsfunc[1:0] 00/01/10/11 gives size 1/2/4/8 bytes.
  - wmask = (0x01/0x03/0x0F/0xFF) << off.
  - wdata = rs2 << (off*8).
  - `o_mem_wmask`=0 for loads.
- `o_lsu_rdwen` = registered rdwen.
  - For stores, upstream supplies rdwen=0; the LSU does not force it.
- lden and sten both set: treated as a load.

## Timing
- Reset: state EMPTY, and every register and output is 0, including `o_pre_ready`.
  - `o_pre_ready` becomes 1 in the first cycle after reset deasserts.
- Reset asserted in MEM abandons the request: `o_mem_req`=0 in the next cycle, and any later ack is ignored.
- Non-memory instruction: captured at edge N, `o_post_valid`=1 in cycle N+1.
- Memory instruction:
  - Captured at edge N, `o_mem_req`=1 from cycle N+1.
  - Ack in cycle M (M≥N+1): `o_post_valid`=1 in cycle M+1.
  - Minimum latency is 2 cycles.
- Back-to-back: HOLD & `i_post_ready` & `i_pre_valid` replaces the result in the same edge, so there is no bubble.
- Back-pressure: with `i_post_ready`=0, the result and `o_post_valid` are held indefinitely.
- `i_mem_ack` outside MEM is ignored.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined:
  - A load/store whose off is not a multiple of its size goes directly to HOLD with no memory request.
  - It has `o_lsu_misalign`=1 and `o_lsu_rdwen`=0 for that result.
- `LSU_MISALIGN_CHK_EN` undefined:
  - `o_lsu_misalign` is tied 0.
  - Low offset bits below the access size are cleared and the access is issued normally.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `o_pre_ready`=1 in the first cycle after release.
- ALU op, exres=0x1234, rdid=5, rdwen=1, `i_post_ready`=1 → `o_post_valid` one cycle later with exres=0x1234, rdid=5, rdwen=1, lden=0, `o_mem_req` never asserted.
- lb at addr 0x8000_0003, rdata=0x0000_0000_8000_0000, ack after 3 wait cycles:
  - `o_mem_addr`=0x8000_0000.
  - lsres=0xFFFF_FFFF_FFFF_FF80.
  - `o_pre_ready`=0 while waiting.
  - Same access as lbu → 0x80.
- sh at 0x8000_0006, rs2=0xABCD → wmask=0xC0, wdata=0xABCD_0000_0000_0000, wen=1; held stable through 2 wait cycles.
- Three back-to-back ALU ops with `i_post_ready` low for 2 cycles on the second → no instruction dropped or duplicated; results appear in order.
- With `LSU_MISALIGN_CHK_EN`, lw at 0x8000_0002 → no `o_mem_req`; `o_post_valid` next cycle with misalign=1, rdwen=0.

Source files
------------

// File: rtl/lsu.sv
// Load/store pipeline stage: one instruction per handshake, single memory access, load extension, store lane masks.
// Optional LSU_MISALIGN_CHK_EN: misaligned accesses skip memory and are flagged instead of offset-truncated.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif

module lsu (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_pre_valid,
   output logic                   o_pre_ready,
   input  logic [`CPU_WIDTH-1:0]  i_exu_exres,
   input  logic [`CPU_WIDTH-1:0]  i_exu_rs2,
   input  logic [2:0]             i_exu_lsfunc,
   input  logic                   i_exu_lden,
   input  logic                   i_exu_sten,
   input  logic [`REG_ADDRW-1:0]  i_exu_rdid,
   input  logic                   i_exu_rdwen,
   input  logic [`CPU_WIDTH-1:0]  s_exu_diffpc,
   output logic                   o_mem_req,
   output logic                   o_mem_wen,
   output logic [`CPU_WIDTH-1:0]  o_mem_addr,
   output logic [`CPU_WIDTH-1:0]  o_mem_wdata,
   output logic [7:0]             o_mem_wmask,
   input  logic                   i_mem_ack,
   input  logic [`CPU_WIDTH-1:0]  i_mem_rdata,
   output logic                   o_post_valid,
   input  logic                   i_post_ready,
   output logic [`CPU_WIDTH-1:0]  o_lsu_exres,
   output logic [`CPU_WIDTH-1:0]  o_lsu_lsres,
   output logic [`REG_ADDRW-1:0]  o_lsu_rdid,
   output logic                   o_lsu_rdwen,
   output logic                   o_lsu_lden,
   output logic                   o_lsu_misalign,
   output logic [`CPU_WIDTH-1:0]  s_lsu_diffpc
);
   localparam int unsigned XW = `CPU_WIDTH;
   localparam int unsigned RW = `REG_ADDRW;

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_MEM = 2'd1, S_HOLD = 2'd2} state_e;

   state_e        state_q, state_d;
   logic [XW-1:0] exres_q, rs2_q, pc_q, lsres_q;
   logic [2:0]    lsfunc_q;
   logic          lden_q, sten_q, rdwen_q, misalign_q;
   logic [RW-1:0] rdid_q;

   logic          pipewen;
   logic          mis_in;
   logic [2:0]    low_mask_q;
   logic [2:0]    off_eff;
   logic [XW-1:0] rd_shift;
   logic [XW-1:0] ld_ext;
   logic [7:0]    size_mask;

   // Incoming access is misaligned when offset bits below its size are set
`ifdef LSU_MISALIGN_CHK_EN
   logic [2:0] low_mask_in;
   assign low_mask_in = 3'((4'd1 << i_exu_lsfunc[1:0]) - 4'd1);
   assign mis_in      = (i_exu_lden | i_exu_sten) & (|(i_exu_exres[2:0] & low_mask_in));
`else
   assign mis_in = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      o_pre_ready = 1'b0;
      pipewen     = 1'b0;
      if (!i_rst) begin
         o_pre_ready = (state_q == S_EMPTY) | ((state_q == S_HOLD) & i_post_ready);
      end
      pipewen = i_pre_valid & o_pre_ready;
      case (state_q)
         S_EMPTY, S_HOLD: begin
            if (pipewen) begin
               state_d = ((i_exu_lden | i_exu_sten) & ~mis_in) ? S_MEM : S_HOLD;
            end else if ((state_q == S_HOLD) && i_post_ready) begin
               state_d = S_EMPTY;
            end
         end
         S_MEM:   if (i_mem_ack) state_d = S_HOLD;
         default: state_d = S_EMPTY;
      endcase
   end

   // Size-aligned lane offset; low bits below the access size are dropped
   assign low_mask_q = 3'((4'd1 << lsfunc_q[1:0]) - 4'd1);
   assign off_eff    = exres_q[2:0] & ~low_mask_q;
   assign rd_shift   = i_mem_rdata >> {off_eff, 3'b000};

   always_comb begin
      ld_ext = rd_shift;
      case (lsfunc_q)
         3'b000:  ld_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
         3'b001:  ld_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
         3'b010:  ld_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
         3'b100:  ld_ext = {56'd0, rd_shift[7:0]};
         3'b101:  ld_ext = {48'd0, rd_shift[15:0]};
         3'b110:  ld_ext = {32'd0, rd_shift[31:0]};
         default: ld_ext = rd_shift;
      endcase
   end

   always_comb begin
      size_mask = 8'hFF;
      case (lsfunc_q[1:0])
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         exres_q    <= '0;
         rs2_q      <= '0;
         pc_q       <= '0;
         lsres_q    <= '0;
         lsfunc_q   <= '0;
         lden_q     <= 1'b0;
         sten_q     <= 1'b0;
         rdwen_q    <= 1'b0;
         misalign_q <= 1'b0;
         rdid_q     <= '0;
      end else if (pipewen) begin
         exres_q    <= i_exu_exres;
         rs2_q      <= i_exu_rs2;
         pc_q       <= s_exu_diffpc;
         lsres_q    <= '0;
         lsfunc_q   <= i_exu_lsfunc;
         lden_q     <= i_exu_lden;
         sten_q     <= i_exu_sten;
         rdwen_q    <= i_exu_rdwen & ~mis_in;
         misalign_q <= mis_in;
         rdid_q     <= i_exu_rdid;
      end else if ((state_q == S_MEM) && i_mem_ack && lden_q) begin
         lsres_q <= ld_ext;
      end
   end

   // A set lden wins over sten, so a dual-flagged op is issued as a load
   assign o_mem_req      = (state_q == S_MEM);
   assign o_mem_wen      = sten_q & ~lden_q;
   assign o_mem_addr     = {exres_q[XW-1:3], 3'b000};
   assign o_mem_wdata    = rs2_q << {off_eff, 3'b000};
   assign o_mem_wmask    = o_mem_wen ? 8'(size_mask << off_eff) : 8'h00;
   assign o_post_valid   = (state_q == S_HOLD);
   assign o_lsu_exres    = exres_q;
   assign o_lsu_lsres    = lsres_q;
   assign o_lsu_rdid     = rdid_q;
   assign o_lsu_rdwen    = rdwen_q;
   assign o_lsu_lden     = lden_q;
   assign o_lsu_misalign = misalign_q;
   assign s_lsu_diffpc   = pc_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, corner sequences, and randomized ops vs a byte-level model.
module tb_lsu;
   logic        i_clk = 1'b0;
   logic        i_rst, i_pre_valid, o_pre_ready;
   logic [63:0] i_exu_exres, i_exu_rs2, s_exu_diffpc;
   logic [2:0]  i_exu_lsfunc;
   logic        i_exu_lden, i_exu_sten, i_exu_rdwen;
   logic [4:0]  i_exu_rdid;
   logic        o_mem_req, o_mem_wen;
   logic [63:0] o_mem_addr, o_mem_wdata;
   logic [7:0]  o_mem_wmask;
   logic        i_mem_ack;
   logic [63:0] i_mem_rdata;
   logic        o_post_valid, i_post_ready;
   logic [63:0] o_lsu_exres, o_lsu_lsres, s_lsu_diffpc;
   logic [4:0]  o_lsu_rdid;
   logic        o_lsu_rdwen, o_lsu_lden, o_lsu_misalign;

   int total = 0;
   int bad   = 0;

   lsu dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
      .i_exu_exres(i_exu_exres), .i_exu_rs2(i_exu_rs2), .i_exu_lsfunc(i_exu_lsfunc),
      .i_exu_lden(i_exu_lden), .i_exu_sten(i_exu_sten), .i_exu_rdid(i_exu_rdid),
      .i_exu_rdwen(i_exu_rdwen), .s_exu_diffpc(s_exu_diffpc),
      .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata), .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
      .o_lsu_exres(o_lsu_exres), .o_lsu_lsres(o_lsu_lsres), .o_lsu_rdid(o_lsu_rdid),
      .o_lsu_rdwen(o_lsu_rdwen), .o_lsu_lden(o_lsu_lden), .o_lsu_misalign(o_lsu_misalign),
      .s_lsu_diffpc(s_lsu_diffpc)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [63:0] exres;
      logic [63:0] rs2;
      logic [2:0]  func;
      logic        lden;
      logic        sten;
      logic [63:0] rdata;
      int          waits;
      logic [63:0] exp_ls;
      logic [7:0]  exp_mask;
      logic [63:0] exp_wdata;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Reference: pick bytes from the doubleword, then extend by size and signedness
   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off, input logic [2:0] func);
      int          size;
      logic [63:0] v, m;
      size = 1 << func[1:0];
      v    = rdata >> (off * 8);
      m    = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (size * 8)) - 64'd1);
      v    = v & m;
      if (!func[2] && size < 8 && v[size*8-1]) v = v | ~m;
      return v;
   endfunction

   task automatic run_op(input string tag, input logic [63:0] exres, input logic [63:0] rs2,
                         input logic [2:0] func, input logic lden, input logic sten,
                         input logic [4:0] rdid, input logic rdwen, input logic [63:0] rdata,
                         input int waits, input logic exp_mis, input logic [63:0] exp_ls,
                         input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
      logic [63:0] pc;
      logic        is_st;
      pc    = {$urandom, $urandom};
      is_st = sten & ~lden;
      chk({tag, " pre_ready idle"}, 64'(o_pre_ready), 64'd1);
      i_exu_exres = exres; i_exu_rs2 = rs2; i_exu_lsfunc = func; i_exu_lden = lden;
      i_exu_sten = sten; i_exu_rdid = rdid; i_exu_rdwen = rdwen; s_exu_diffpc = pc;
      i_pre_valid = 1'b1;
      step();
      i_pre_valid = 1'b0;
      i_exu_exres = {$urandom, $urandom}; i_exu_rs2 = {$urandom, $urandom};
      s_exu_diffpc = {$urandom, $urandom};
      if ((lden | sten) && !exp_mis) begin
         chk({tag, " wen"}, 64'(o_mem_wen), 64'(is_st));
         chk({tag, " wmask"}, 64'(o_mem_wmask), is_st ? 64'(exp_mask) : 64'd0);
         if (is_st) chk({tag, " wdata"}, o_mem_wdata, exp_wdata);
         for (int w = 0; w <= waits; w++) begin
            chk({tag, " mem_req"}, 64'(o_mem_req), 64'd1);
            chk({tag, " addr"}, o_mem_addr, {exres[63:3], 3'b000});
            chk({tag, " pre_ready busy"}, 64'(o_pre_ready), 64'd0);
            chk({tag, " post_valid busy"}, 64'(o_post_valid), 64'd0);
            if (is_st) chk({tag, " wmask held"}, 64'(o_mem_wmask), 64'(exp_mask));
            if (w < waits) step();
         end
         i_mem_ack = 1'b1; i_mem_rdata = rdata;
         step();
         i_mem_ack = 1'b0; i_mem_rdata = {$urandom, $urandom};
      end else begin
         chk({tag, " no mem_req"}, 64'(o_mem_req), 64'd0);
      end
      chk({tag, " post_valid"}, 64'(o_post_valid), 64'd1);
      chk({tag, " mem_req done"}, 64'(o_mem_req), 64'd0);
      chk({tag, " exres"}, o_lsu_exres, exres);
      chk({tag, " rdid"}, 64'(o_lsu_rdid), 64'(rdid));
      chk({tag, " rdwen"}, 64'(o_lsu_rdwen), exp_mis ? 64'd0 : 64'(rdwen));
      chk({tag, " lden"}, 64'(o_lsu_lden), 64'(lden));
      chk({tag, " misalign"}, 64'(o_lsu_misalign), 64'(exp_mis));
      chk({tag, " diffpc"}, s_lsu_diffpc, pc);
      if (lden && !exp_mis) chk({tag, " lsres"}, o_lsu_lsres, exp_ls);
      step();
      chk({tag, " drained"}, 64'(o_post_valid), 64'd0);
   endtask

   vec_t tbl[8];

   initial begin
      i_rst = 1'b1; i_pre_valid = 1'b0; i_post_ready = 1'b1; i_mem_ack = 1'b0;
      i_mem_rdata = '0; i_exu_exres = '0; i_exu_rs2 = '0; i_exu_lsfunc = '0;
      i_exu_lden = 1'b0; i_exu_sten = 1'b0; i_exu_rdid = '0; i_exu_rdwen = 1'b0;
      s_exu_diffpc = '0;

      // exres, rs2, func, lden, sten, rdata, waits, exp_ls, exp_mask, exp_wdata
      tbl[0] = '{64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 64'h0, 0, 64'h0, 8'h00, 64'h0};
      tbl[1] = '{64'h8000_0003, 64'h0, 3'b000, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 3,
                 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0};
      tbl[2] = '{64'h8000_0003, 64'h0, 3'b100, 1'b1, 1'b0, 64'h0000_0000_8000_0000, 3,
                 64'h80, 8'h00, 64'h0};
      tbl[3] = '{64'h8000_0006, 64'hABCD, 3'b001, 1'b0, 1'b1, 64'h0, 2,
                 64'h0, 8'hC0, 64'hABCD_0000_0000_0000};
      tbl[4] = '{64'h8000_0008, 64'h0, 3'b011, 1'b1, 1'b0, 64'h8123_4567_89AB_CDEF, 0,
                 64'h8123_4567_89AB_CDEF, 8'h00, 64'h0};
      tbl[5] = '{64'h8000_0014, 64'h0, 3'b010, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1,
                 64'hFFFF_FFFF_8000_0000, 8'h00, 64'h0};
      tbl[6] = '{64'h8000_0022, 64'h0, 3'b101, 1'b1, 1'b0, 64'h0000_0000_F00D_0000, 0,
                 64'hF00D, 8'h00, 64'h0};
      tbl[7] = '{64'h8000_0030, 64'h1122_3344_5566_7788, 3'b011, 1'b0, 1'b1, 64'h0, 1,
                 64'h0, 8'hFF, 64'h1122_3344_5566_7788};

      // Reset held three cycles: everything reads zero, ready rises on release
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst pre_ready", 64'(o_pre_ready), 64'd0);
         chk("rst post_valid", 64'(o_post_valid), 64'd0);
         chk("rst mem_req", 64'(o_mem_req), 64'd0);
         chk("rst exres", o_lsu_exres, 64'd0);
         chk("rst wmask", 64'(o_mem_wmask), 64'd0);
      end
      chk("rst lsres", o_lsu_lsres, 64'd0);
      chk("rst diffpc", s_lsu_diffpc, 64'd0);
      i_rst = 1'b0;
      #1;
      chk("release pre_ready", 64'(o_pre_ready), 64'd1);

      // Stray ack while empty is ignored
      i_mem_ack = 1'b1;
      step();
      i_mem_ack = 1'b0;
      chk("stray ack post_valid", 64'(o_post_valid), 64'd0);
      chk("stray ack mem_req", 64'(o_mem_req), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].exres, tbl[i].rs2, tbl[i].func, tbl[i].lden,
                tbl[i].sten, 5'(i + 5), 1'b1, tbl[i].rdata, tbl[i].waits, 1'b0,
                tbl[i].exp_ls, tbl[i].exp_mask, tbl[i].exp_wdata);
      end

      // Misaligned lw: trapped when checking is on, offset-truncated otherwise
`ifdef LSU_MISALIGN_CHK_EN
      run_op("mis_lw", 64'h8000_0002, 64'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1,
             64'h0, 0, 1'b1, 64'h0, 8'h00, 64'h0);
`else
      run_op("mis_lw", 64'h8000_0002, 64'h0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1,
             64'h1111_2222_8765_4321, 0, 1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0);
`endif

      // Three back-to-back ALU ops with write-back stalled on the second
      i_exu_lden = 1'b0; i_exu_sten = 1'b0; i_exu_rdwen = 1'b1;
      i_exu_exres = 64'hA1; i_exu_rdid = 5'd1; i_pre_valid = 1'b1;
      step();
      chk("b2b first", o_lsu_exres, 64'hA1);
      i_exu_exres = 64'hB2; i_exu_rdid = 5'd2;
      #1;
      chk("b2b ready on hold", 64'(o_pre_ready), 64'd1);
      step();
      chk("b2b second", o_lsu_exres, 64'hB2);
      chk("b2b second rdid", 64'(o_lsu_rdid), 64'd2);
      i_exu_exres = 64'hC3; i_exu_rdid = 5'd3; i_post_ready = 1'b0;
      #1;
      chk("b2b stall ready", 64'(o_pre_ready), 64'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("b2b stall valid", 64'(o_post_valid), 64'd1);
         chk("b2b stall hold", o_lsu_exres, 64'hB2);
      end
      i_post_ready = 1'b1;
      step();
      i_pre_valid = 1'b0;
      chk("b2b third", o_lsu_exres, 64'hC3);
      chk("b2b third rdid", 64'(o_lsu_rdid), 64'd3);
      step();
      chk("b2b drained", 64'(o_post_valid), 64'd0);

      // Reset during an outstanding load abandons it; a late ack is dropped
      i_exu_exres = 64'h8000_0040; i_exu_lden = 1'b1; i_exu_lsfunc = 3'b011; i_pre_valid = 1'b1;
      step();
      i_pre_valid = 1'b0; i_exu_lden = 1'b0;
      chk("abort req before", 64'(o_mem_req), 64'd1);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("abort req", 64'(o_mem_req), 64'd0);
      i_mem_ack = 1'b1; i_mem_rdata = 64'hDEAD;
      step();
      i_mem_ack = 1'b0;
      chk("abort late ack", 64'(o_post_valid), 64'd0);
      chk("abort lsres", o_lsu_lsres, 64'd0);

      // Randomized ops against the byte-level model
      for (int n = 0; n < 60; n++) begin
         logic [63:0] ex, rs, rd, e_ls, e_wd;
         logic [2:0]  fn;
         logic        ld, st, mis;
         logic [7:0]  e_mk;
         int          kind, size, off, eoff;
         ex   = {32'h0, 32'h8000_0000 | $urandom_range(0, 32'hFFFF)};
         rs   = {$urandom, $urandom};
         rd   = {$urandom, $urandom};
         fn   = 3'($urandom);
         kind = $urandom_range(0, 3);
         ld   = (kind == 1) || (kind == 3);
         st   = (kind == 2) || (kind == 3);
         if (st && !ld) fn[2] = 1'b0;
         size = 1 << fn[1:0];
         off  = int'(ex[2:0]);
         mis  = (ld | st) && (off % size != 0);
         eoff = off - (off % size);
`ifndef LSU_MISALIGN_CHK_EN
         mis  = 1'b0;
`endif
         e_ls = model_load(rd, eoff, fn);
         e_mk = 8'(((1 << size) - 1) << eoff);
         e_wd = rs << (eoff * 8);
         run_op($sformatf("rnd%0d", n), ex, rs, fn, ld, st, 5'($urandom), 1'($urandom), rd,
                $urandom_range(0, 3), mis, e_ls, e_mk, e_wd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
